fir_coeff_arb: RTL and testbench

Coefficient-memory arbiter sitting between the `fir` core's coefficient read port and the single-port 32×64 coefficient SRAM. It shares that SRAM with a host write (configuration) stream. FIR reads always win, because the core expects a fixed one-cycle read latency. Host writes are buffered and committed in cycles with no FIR read. An optional starvation guard pauses the FIR input stream so a pending write is guaranteed to complete.

---
 rtl/fir_coeff_arb.sv | 84 ++++++++
 tb/tb_fir_coeff_arb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fir_coeff_arb.sv
// fir_coeff_arb: shares the single-port coefficient SRAM between FIR reads (always win) and buffered host writes.
// Define FIR_COEFF_ARB_STARVE_GUARD_EN to add the HOLD state that gates FIR input so a pending write completes.
module fir_coeff_arb #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 64,
    parameter int IN_W       = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fir_radr,
    input  logic              fir_re,
    output logic [DATA_W-1:0] fir_q,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q,
    input  logic [ADDR_W-1:0] host_adr,
    input  logic [DATA_W-1:0] host_dat,
    input  logic              host_vld,
    output logic              host_rdy,
    input  logic [IN_W-1:0]   in_dat,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [IN_W-1:0]   fir_in_dat,
    output logic              fir_in_vld,
    input  logic              fir_in_rdy,
    output logic              coeff_upd,
    output logic [15:0]       wr_cnt
);
    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
    state_t            state;
    logic [ADDR_W-1:0] buf_adr;
    logic [DATA_W-1:0] buf_dat;
    logic              commit, gate, accept;
`ifdef FIR_COEFF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve;
`endif
    assign commit     = rst && state != IDLE && !fir_re;
    assign host_rdy   = rst && state == IDLE;
    assign accept     = host_rdy && host_vld;
    assign gate       = !rst || state == HOLD;
    assign mem_re     = fir_re;
    assign mem_we     = commit;
    assign mem_adr    = fir_re ? fir_radr : buf_adr;
    assign mem_d      = buf_dat;
    assign fir_q      = mem_q;
    assign fir_in_dat = in_dat;
    assign fir_in_vld = in_vld && !gate;
    assign in_rdy     = fir_in_rdy && !gate;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            buf_adr   <= '0;
            buf_dat   <= '0;
            wr_cnt    <= '0;
            coeff_upd <= 1'b0;
`ifdef FIR_COEFF_ARB_STARVE_GUARD_EN
            starve    <= '0;
`endif
        end else begin
            coeff_upd <= commit;
            if (commit) begin
                state  <= IDLE;
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (accept) begin
                state   <= PEND;
                buf_adr <= host_adr;
                buf_dat <= host_dat;
            end
`ifdef FIR_COEFF_ARB_STARVE_GUARD_EN
            // counter only advances on conflicting reads while waiting in PEND
            if (accept) starve <= '0;
            else if (state == PEND && fir_re) begin
                starve <= starve + 1'b1;
                if (starve == SW'(STARVE_MAX - 1)) state <= HOLD;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fir_coeff_arb.sv
// tb_fir_coeff_arb: directed and random stimulus against a transaction-level model of the arbiter.
// Expectations follow FIR_COEFF_ARB_STARVE_GUARD_EN the same way the design does.
module tb_fir_coeff_arb;
    localparam int SM = 4;
`ifdef FIR_COEFF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic        clk = 1'b0, rst, fir_re, mem_re, mem_we, host_vld, host_rdy;
    logic        in_vld, in_rdy, fir_in_vld, fir_in_rdy, coeff_upd;
    logic [4:0]  fir_radr, mem_adr, host_adr;
    logic [63:0] fir_q, mem_d, mem_q, host_dat;
    logic [7:0]  in_dat, fir_in_dat;
    logic [15:0] wr_cnt;
    logic [63:0] sram [32];
    int          checks = 0, errors = 0;
    logic [63:0] ref_mem [32];
    bit          ref_ok [32];
    bit          pend, hold, upd, prev_re;
    int          age;
    logic [4:0]  pa, prev_adr;
    logic [63:0] pd;
    logic [15:0] cnt;

    fir_coeff_arb #(.ADDR_W(5), .DATA_W(64), .IN_W(8), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .fir_radr(fir_radr), .fir_re(fir_re), .fir_q(fir_q),
        .mem_adr(mem_adr), .mem_re(mem_re), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
        .host_adr(host_adr), .host_dat(host_dat), .host_vld(host_vld), .host_rdy(host_rdy),
        .in_dat(in_dat), .in_vld(in_vld), .in_rdy(in_rdy),
        .fir_in_dat(fir_in_dat), .fir_in_vld(fir_in_vld), .fir_in_rdy(fir_in_rdy),
        .coeff_upd(coeff_upd), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) sram[mem_adr] <= mem_d;
        if (mem_re) mem_q <= sram[mem_adr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet();
        rst = 1'b1; fir_re = 1'b0; fir_radr = 5'($urandom); host_vld = 1'b0;
        host_adr = 5'($urandom); host_dat = {$urandom, $urandom};
        in_vld = 1'b1; in_dat = 8'($urandom); fir_in_rdy = 1'b1;
    endtask

    // called at posedge+1 with inputs already driven; checks before the next edge, then advances the model
    task automatic step();
        bit er, ec, eg;
        #7;
        er = rst && !pend;
        ec = rst && pend && !fir_re;
        eg = !rst || hold;
        chk("host_rdy", host_rdy, er);
        chk("mem_we", mem_we, ec);
        chk("mem_re", mem_re, fir_re);
        if (fir_re) chk("rd_adr", mem_adr, fir_radr);
        if (ec) begin
            chk("wr_adr", mem_adr, pa);
            chk("wr_dat", mem_d, pd);
        end
        chk("in_rdy", in_rdy, fir_in_rdy && !eg);
        chk("fir_in_vld", fir_in_vld, in_vld && !eg);
        chk("fir_in_dat", fir_in_dat, in_dat);
        chk("coeff_upd", coeff_upd, upd);
        chk("wr_cnt", wr_cnt, cnt);
        if (prev_re && ref_ok[prev_adr]) chk("fir_q", fir_q, ref_mem[prev_adr]);
        @(posedge clk);
        prev_re = fir_re;
        prev_adr = fir_radr;
        if (!rst) begin
            pend = 0; hold = 0; age = 0; upd = 0; cnt = 0;
        end else begin
            upd = ec;
            if (ec) begin
                cnt++;
                ref_mem[pa] = pd;
                ref_ok[pa] = 1;
                pend = 0;
                hold = 0;
            end else if (pend && fir_re && !hold) begin
                age++;
                if (GUARD && age == SM) hold = 1;
            end
            if (er && host_vld) begin
                pend = 1; age = 0; pa = host_adr; pd = host_dat;
            end
        end
        #1;
    endtask

    initial begin
        pend = 0; hold = 0; upd = 0; prev_re = 0; age = 0; cnt = 0; pa = '0; pd = '0; prev_adr = '0;
        for (int i = 0; i < 32; i++) ref_ok[i] = 0;
        quiet();
        rst = 1'b0;
        @(posedge clk);
        #1;
        host_vld = 1'b1;
        repeat (3) step();
        quiet();
        step();
        // idle write then read it back
        host_vld = 1'b1; host_adr = 5'd5; host_dat = 64'h0123_4567_89AB_CDEF;
        step();
        quiet(); step(); step();
        fir_re = 1'b1; fir_radr = 5'd5; step();
        quiet(); step();
        // write accepted under a 4-cycle read burst
        fir_re = 1'b1; host_vld = 1'b1; host_adr = 5'd9;
        step();
        host_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin fir_radr = 5'(i + 4); step(); end
        quiet(); step(); step();
        // continuous reads: guard engages, or the write stays stuck for 100 cycles
        host_vld = 1'b1; host_adr = 5'd12; fir_re = 1'b1; step();
        host_vld = 1'b0;
        repeat (GUARD ? 8 : 100) begin fir_radr = 5'($urandom); step(); end
        quiet(); step(); step(); step();
        // wrap of the commit counter
        force dut.wr_cnt = 16'hFFFF;
        release dut.wr_cnt;
        cnt = 16'hFFFF;
        host_vld = 1'b1; host_adr = 5'd1; step();
        quiet(); step(); step();
        // reset while a write is pending discards it
        host_vld = 1'b1; host_adr = 5'd2; fir_re = 1'b1; step();
        host_vld = 1'b0; step();
        rst = 1'b0; step();
        quiet(); step(); step(); step();
        // random traffic with occasional reset
        repeat (3000) begin
            rst = ($urandom_range(0, 99) != 0);
            fir_re = ($urandom_range(0, 3) != 0);
            fir_radr = 5'($urandom);
            host_vld = $urandom_range(0, 1) == 1;
            host_adr = 5'($urandom);
            host_dat = {$urandom, $urandom};
            in_vld = $urandom_range(0, 1) == 1;
            in_dat = 8'($urandom);
            fir_in_rdy = $urandom_range(0, 1) == 1;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
